mem_store_buffer: RTL and testbench

//  Posted-write store buffer between the MEM stage (EX/MEM outputs) and the data memory port.

---
 rtl/mem_store_buffer.sv | 219 +++++++++++++++++++++
 tb/tb_mem_store_buffer.sv | 328 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_store_buffer.sv
`default_nettype none
// ============================================================================
// Module      : mem_store_buffer
// Description : Posted-write store buffer between the MEM stage and the data
//               memory port. A store retires from the pipeline in one cycle
//               and is written to memory in the background. A load that hits
//               a buffered word is forwarded from the buffer. A load that
//               misses goes to memory.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Parameters
//   DEPTH   store entries (power of 2, >= 2)
//   ADDR_W  byte address width; word compare uses [ADDR_W-1:2]
//   DATA_W  store/load data width
// Ports
//   clk           in   rising-edge clock
//   reset         in   asynchronous, active-low; clears all state
//   MemWrite      in   MEM-stage store request
//   MemRead       in   MEM-stage load request (exclusive with MemWrite)
//   address       in   MEM-stage byte address
//   writeData     in   store data
//   readData      out  load result to MEM/WB
//   holdMEM       out  pipeline stall request
//   memWriteEn    out  memory write request
//   memReadEn     out  memory read request
//   memAddress    out  memory address
//   memWriteData  out  memory write data
//   memReadData   in   memory read data, valid in the memAck cycle
//   memAck        in   one-cycle completion pulse for the current request
//   bufCount      out  occupied entries
//   bufEmpty      out  bufCount == 0
// ============================================================================
module mem_store_buffer #(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     MemWrite,
  input  logic                     MemRead,
  input  logic [ADDR_W-1:0]        address,
  input  logic [DATA_W-1:0]        writeData,
  output logic [DATA_W-1:0]        readData,
  output logic                     holdMEM,
  output logic                     memWriteEn,
  output logic                     memReadEn,
  output logic [ADDR_W-1:0]        memAddress,
  output logic [DATA_W-1:0]        memWriteData,
  input  logic [DATA_W-1:0]        memReadData,
  input  logic                     memAck,
  output logic [$clog2(DEPTH):0]   bufCount,
  output logic                     bufEmpty
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL_COUNT = CNT_W'(DEPTH);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRAIN = 2'd1,
    LOAD  = 2'd2
  } state_t;

  state_t             state;
  state_t             state_next;
  logic [PTR_W-1:0]   head;
  logic [PTR_W-1:0]   tail;
  logic [CNT_W-1:0]   count;

  logic [ADDR_W-1:0]  addr_mem [DEPTH];
  logic [DATA_W-1:0]  data_mem [DEPTH];

  // Per-slot age (distance from head) and word-address match.
  logic [PTR_W-1:0]   slot_off   [DEPTH];
  logic [DEPTH-1:0]   slot_match;

  logic               hit;
  logic [DATA_W-1:0]  hit_data;
  logic [PTR_W-1:0]   best_off;

  logic               pop;
  logic               load_ack;
  logic               load_miss;
  logic               full_stall;
  logic               load_wait;
  logic               enqueue;

  // --------------------------------------------------------------------------
  // Forwarding compare
  // --------------------------------------------------------------------------
  generate
    for (genvar s = 0; s < DEPTH; s++) begin : g_slot
      assign slot_off[s]   = PTR_W'(s) - head;
      assign slot_match[s] = ({1'b0, slot_off[s]} < count) &&
                             (addr_mem[s][ADDR_W-1:2] == address[ADDR_W-1:2]);
    end
  endgenerate

  // The youngest matching entry is the one farthest from head. It holds the
  // most recent value for that word.
  always_comb begin
    hit      = 1'b0;
    hit_data = '0;
    best_off = '0;
    for (int s = 0; s < DEPTH; s++) begin
      if (slot_match[s] && (!hit || (slot_off[s] > best_off))) begin
        hit      = 1'b1;
        best_off = slot_off[s];
        hit_data = data_mem[s];
      end
    end
  end

  // --------------------------------------------------------------------------
  // Stall / enqueue control
  // --------------------------------------------------------------------------
  assign pop       = (state == DRAIN) && memAck;
  assign load_ack  = (state == LOAD) && memAck;
  assign load_miss = MemRead && !hit;

  // A full buffer still takes a store when the head drains on the same edge.
  assign full_stall = MemWrite && (count == FULL_COUNT) && !pop;
  assign load_wait  = load_miss && !load_ack;
  assign holdMEM    = full_stall || load_wait;
  assign enqueue    = MemWrite && !holdMEM;

  assign bufCount = count;
  assign bufEmpty = (count == '0);

  always_comb begin
    if (MemRead && hit) begin
      readData = hit_data;
    end else if (load_ack) begin
      readData = memReadData;
    end else begin
      readData = '0;
    end
  end

  // --------------------------------------------------------------------------
  // Entry storage (data only, no reset needed)
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (enqueue) begin
      addr_mem[tail] <= address;
      data_mem[tail] <= writeData;
    end
  end

  // --------------------------------------------------------------------------
  // Pointers, occupancy and state register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      state <= state_next;
      if (enqueue) begin
        tail <= tail + PTR_W'(1);
      end
      if (pop) begin
        head <= head + PTR_W'(1);
      end
      case ({enqueue, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // --------------------------------------------------------------------------
  // Memory-port FSM: one outstanding request, never aborted.
  // --------------------------------------------------------------------------
  always_comb begin
    state_next   = state;
    memWriteEn   = 1'b0;
    memReadEn    = 1'b0;
    memAddress   = '0;
    memWriteData = '0;
    case (state)
      IDLE: begin
        // A waiting load takes priority over background draining.
        if (load_miss) begin
          state_next = LOAD;
        end else if (count != '0) begin
          state_next = DRAIN;
        end
      end
      DRAIN: begin
        memWriteEn   = 1'b1;
        memAddress   = addr_mem[head];
        memWriteData = data_mem[head];
        if (memAck) begin
          state_next = IDLE;
        end
      end
      LOAD: begin
        // A load miss may bypass older stores: any same-word store would
        // have hit in the buffer instead.
        memReadEn  = 1'b1;
        memAddress = address;
        if (memAck) begin
          state_next = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

endmodule
`default_nettype wire

// File: tb/tb_mem_store_buffer.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_store_buffer
// Description : Directed self-checking bench for mem_store_buffer
//               (DEPTH=4, ADDR_W=32, DATA_W=32).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_store_buffer;

  localparam int DEPTH  = 4;
  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;

  logic              clk;
  logic              reset;
  logic              MemWrite;
  logic              MemRead;
  logic [ADDR_W-1:0] address;
  logic [DATA_W-1:0] writeData;
  logic [DATA_W-1:0] readData;
  logic              holdMEM;
  logic              memWriteEn;
  logic              memReadEn;
  logic [ADDR_W-1:0] memAddress;
  logic [DATA_W-1:0] memWriteData;
  logic [DATA_W-1:0] memReadData;
  logic              memAck;
  logic [2:0]        bufCount;
  logic              bufEmpty;

  int checks = 0;
  int errors = 0;

  logic [ADDR_W-1:0] exp_addr_q [$];
  logic [DATA_W-1:0] exp_data_q [$];

  mem_store_buffer #(
    .DEPTH (DEPTH),
    .ADDR_W(ADDR_W),
    .DATA_W(DATA_W)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .MemWrite    (MemWrite),
    .MemRead     (MemRead),
    .address     (address),
    .writeData   (writeData),
    .readData    (readData),
    .holdMEM     (holdMEM),
    .memWriteEn  (memWriteEn),
    .memReadEn   (memReadEn),
    .memAddress  (memAddress),
    .memWriteData(memWriteData),
    .memReadData (memReadData),
    .memAck      (memAck),
    .bufCount    (bufCount),
    .bufEmpty    (bufEmpty)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic idle_in();
    MemWrite    = 1'b0;
    MemRead     = 1'b0;
    memAck      = 1'b0;
    memReadData = '0;
  endtask

  task automatic store(input logic [31:0] a, input logic [31:0] d);
    MemWrite  = 1'b1;
    MemRead   = 1'b0;
    address   = a;
    writeData = d;
  endtask

  // Acknowledge every write the DUT issues and compare it against the
  // expected issue order until the buffer is empty.
  task automatic drain_all(input string tag);
    bit done;
    done = 1'b0;
    for (int c = 0; c < 40; c++) begin
      if (bufEmpty) begin
        done = 1'b1;
        break;
      end
      memAck = memWriteEn;
      if (memWriteEn) begin
        if (exp_addr_q.size() == 0) begin
          chk({tag, "_extra_write"}, 64'd1, 64'd0);
        end else begin
          chk({tag, "_addr"}, 64'(memAddress), 64'(exp_addr_q[0]));
          chk({tag, "_data"}, 64'(memWriteData), 64'(exp_data_q[0]));
          void'(exp_addr_q.pop_front());
          void'(exp_data_q.pop_front());
        end
      end
      tick();
      memAck = 1'b0;
    end
    chk({tag, "_drained"}, 64'(done), 64'd1);
    chk({tag, "_queue_left"}, 64'(exp_addr_q.size()), 64'd0);
  endtask

  initial begin
    reset     = 1'b0;
    address   = '0;
    writeData = '0;
    idle_in();

    // ---------------- Reset values ----------------
    #12;
    chk("rst_count", 64'(bufCount), 64'd0);
    chk("rst_empty", 64'(bufEmpty), 64'd1);
    chk("rst_hold", 64'(holdMEM), 64'd0);
    chk("rst_wen", 64'(memWriteEn), 64'd0);
    chk("rst_ren", 64'(memReadEn), 64'd0);
    chk("rst_rdata", 64'(readData), 64'd0);
    tick();
    reset = 1'b1;

    // ---------------- Test 1: async reset with 3 entries ----------------
    store(32'h500, 32'h1); tick();
    store(32'h504, 32'h2); tick();
    store(32'h508, 32'h3); tick();
    idle_in();
    settle();
    chk("t1_count3", 64'(bufCount), 64'd3);
    chk("t1_wen_before", 64'(memWriteEn), 64'd1);
    reset = 1'b0;
    settle();
    chk("t1_async_count", 64'(bufCount), 64'd0);
    chk("t1_async_empty", 64'(bufEmpty), 64'd1);
    chk("t1_async_wen", 64'(memWriteEn), 64'd0);
    chk("t1_async_ren", 64'(memReadEn), 64'd0);
    tick();
    reset = 1'b1;

    // ---------------- Test 2: single store drains ----------------
    store(32'h10, 32'hAAAA);
    settle();
    chk("t2_no_stall", 64'(holdMEM), 64'd0);
    tick();
    idle_in();
    settle();
    chk("t2_idle_wen", 64'(memWriteEn), 64'd0);
    chk("t2_count1", 64'(bufCount), 64'd1);
    tick();
    memAck = 1'b1;
    settle();
    chk("t2_wen", 64'(memWriteEn), 64'd1);
    chk("t2_waddr", 64'(memAddress), 64'h10);
    chk("t2_wdata", 64'(memWriteData), 64'hAAAA);
    tick();
    memAck = 1'b0;
    settle();
    chk("t2_empty", 64'(bufEmpty), 64'd1);
    chk("t2_wen_off", 64'(memWriteEn), 64'd0);

    // ---------------- Test 3: youngest-match forwarding ----------------
    store(32'h20, 32'h1); tick();
    store(32'h20, 32'h2); tick();
    MemWrite = 1'b0;
    MemRead  = 1'b1;
    address  = 32'h22;
    settle();
    chk("t3_rdata", 64'(readData), 64'h2);
    chk("t3_hold", 64'(holdMEM), 64'd0);
    chk("t3_ren", 64'(memReadEn), 64'd0);
    tick();
    settle();
    chk("t3_rdata2", 64'(readData), 64'h2);
    chk("t3_ren2", 64'(memReadEn), 64'd0);
    MemRead = 1'b0;
    memAck  = 1'b1;
    settle();
    chk("t3_d1_addr", 64'(memAddress), 64'h20);
    chk("t3_d1_data", 64'(memWriteData), 64'h1);
    tick();
    memAck = 1'b0;
    tick();
    memAck = 1'b1;
    settle();
    chk("t3_d2_data", 64'(memWriteData), 64'h2);
    tick();
    memAck = 1'b0;
    settle();
    chk("t3_empty", 64'(bufEmpty), 64'd1);

    // ---------------- Test 4: full stall and release ----------------
    store(32'h100, 32'h11); tick();
    store(32'h104, 32'h22); tick();
    store(32'h108, 32'h33); tick();
    store(32'h10C, 32'h44); tick();
    store(32'h110, 32'h55);
    settle();
    chk("t4_count4", 64'(bufCount), 64'd4);
    chk("t4_full_hold", 64'(holdMEM), 64'd1);
    tick();
    settle();
    chk("t4_full_hold2", 64'(holdMEM), 64'd1);
    memAck = 1'b1;
    settle();
    chk("t4_release_hold", 64'(holdMEM), 64'd0);
    chk("t4_pop_addr", 64'(memAddress), 64'h100);
    chk("t4_pop_data", 64'(memWriteData), 64'h11);
    tick();
    idle_in();
    settle();
    chk("t4_count_kept", 64'(bufCount), 64'd4);
    chk("t4_idle_wen", 64'(memWriteEn), 64'd0);
    tick();

    // ---------------- Test 5: load miss during drain ----------------
    MemRead = 1'b1;
    address = 32'h40;
    settle();
    chk("t5_drain_wen", 64'(memWriteEn), 64'd1);
    chk("t5_drain_addr", 64'(memAddress), 64'h104);
    chk("t5_hold_a", 64'(holdMEM), 64'd1);
    chk("t5_ren_a", 64'(memReadEn), 64'd0);
    tick();
    settle();
    chk("t5_hold_b", 64'(holdMEM), 64'd1);
    tick();
    memAck = 1'b1;
    settle();
    chk("t5_hold_c", 64'(holdMEM), 64'd1);
    chk("t5_rdata_c", 64'(readData), 64'd0);
    tick();
    memAck = 1'b0;
    settle();
    chk("t5_hold_idle", 64'(holdMEM), 64'd1);
    chk("t5_idle_ren", 64'(memReadEn), 64'd0);
    chk("t5_idle_wen", 64'(memWriteEn), 64'd0);
    chk("t5_count3", 64'(bufCount), 64'd3);
    tick();
    settle();
    chk("t5_load_ren", 64'(memReadEn), 64'd1);
    chk("t5_load_wen", 64'(memWriteEn), 64'd0);
    chk("t5_load_addr", 64'(memAddress), 64'h40);
    chk("t5_load_hold", 64'(holdMEM), 64'd1);
    tick();
    memAck      = 1'b1;
    memReadData = 32'h1234;
    settle();
    chk("t5_ack_rdata", 64'(readData), 64'h1234);
    chk("t5_ack_hold", 64'(holdMEM), 64'd0);
    tick();
    idle_in();
    settle();
    chk("t5_after_rdata", 64'(readData), 64'd0);
    chk("t5_after_ren", 64'(memReadEn), 64'd0);

    // ---------------- Test 6: wrap with forwarding ----------------
    exp_addr_q.push_back(32'h108); exp_data_q.push_back(32'h33);
    exp_addr_q.push_back(32'h10C); exp_data_q.push_back(32'h44);
    exp_addr_q.push_back(32'h110); exp_data_q.push_back(32'h55);
    drain_all("t6_pre");

    for (int i = 0; i < 10; i++) begin
      store(32'h200 + 32'(4 * i), 32'h1000 + 32'(i));
      settle();
      chk("t6_store_hold", 64'(holdMEM), 64'd0);
      tick();
      MemWrite = 1'b0;
      MemRead  = 1'b1;
      address  = 32'h200 + 32'(4 * i) + 32'(i % 4);
      settle();
      chk("t6_fwd_data", 64'(readData), 64'h1000 + 64'(i));
      chk("t6_fwd_hold", 64'(holdMEM), 64'd0);
      chk("t6_fwd_ren", 64'(memReadEn), 64'd0);
      tick();
      MemRead = 1'b0;
      exp_addr_q.push_back(32'h200 + 32'(4 * i));
      exp_data_q.push_back(32'h1000 + 32'(i));
      drain_all("t6_loop");
    end

    // Multiple live entries after several wraps: youngest same-word wins.
    store(32'h300, 32'hA1); tick();
    store(32'h304, 32'hB2); tick();
    store(32'h300, 32'hC3); tick();
    MemWrite = 1'b0;
    MemRead  = 1'b1;
    address  = 32'h301;
    settle();
    chk("t6_multi_fwd", 64'(readData), 64'hC3);
    chk("t6_multi_hold", 64'(holdMEM), 64'd0);
    address = 32'h304;
    settle();
    chk("t6_multi_fwd2", 64'(readData), 64'hB2);
    tick();
    MemRead = 1'b0;
    exp_addr_q.push_back(32'h300); exp_data_q.push_back(32'hA1);
    exp_addr_q.push_back(32'h304); exp_data_q.push_back(32'hB2);
    exp_addr_q.push_back(32'h300); exp_data_q.push_back(32'hC3);
    drain_all("t6_multi");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
